parking_occupancy_counter: RTL

Occupancy tracker for the parking-lot controller, sitting directly downstream of the entry/exit direction-detection FSM. It consumes that FSM's `ingreso` (vehicle entered) and `egreso` (vehicle left) pulses and maintains the number of vehicles inside. It exposes full/empty status, sticky overflow/underflow error flags, a blinking "lot full" indicator and a registered two-digit BCD copy of the count for the display stage.

---
 rtl/parking_occupancy_counter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/parking_occupancy_counter.sv
// Vehicle occupancy counter fed by the entry/exit detector's ingreso/egreso pulses.
// Tracks the count, full/empty status, sticky error flags, a blinking full LED and BCD digits.
module parking_occupancy_counter #(
  parameter int CAPACITY  = 20,
  parameter int WIDTH     = 7,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ingreso,
  input  logic             egreso,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic             full_led,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units
);

  localparam logic [WIDTH-1:0] CAP        = WIDTH'(CAPACITY);
  localparam int               BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);

  logic             ingreso_d;
  logic             egreso_d;
  logic             entry_ev;
  logic             exit_ev;
  logic [WIDTH-1:0] count_next;
  logic             overflow_next;
  logic             underflow_next;
  logic [3:0]       tens_next;
  logic [3:0]       units_next;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;

  // Rising-edge detection: a level held for many cycles yields one event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ingreso_d <= 1'b0;
      egreso_d  <= 1'b0;
    end else begin
      ingreso_d <= ingreso;
      egreso_d  <= egreso;
    end
  end

  always_comb begin
    entry_ev = ingreso & ~ingreso_d;
    exit_ev  = egreso & ~egreso_d;
  end

  // The BCD digits step alongside the count (+/-1 with carry/borrow), so they
  // always hold count/10 and count%10 without a divider.
  always_comb begin
    count_next     = count;
    overflow_next  = overflow;
    underflow_next = underflow;
    tens_next      = bcd_tens;
    units_next     = bcd_units;
    if (clear) begin
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
      tens_next      = 4'd0;
      units_next     = 4'd0;
    end else if (entry_ev && !exit_ev) begin
      if (count < CAP) begin
        count_next = count + 1'b1;
        if (bcd_units == 4'd9) begin
          units_next = 4'd0;
          tens_next  = bcd_tens + 4'd1;
        end else begin
          units_next = bcd_units + 4'd1;
        end
      end else begin
        overflow_next = 1'b1;
      end
    end else if (exit_ev && !entry_ev) begin
      if (count != '0) begin
        count_next = count - 1'b1;
        if (bcd_units == 4'd0) begin
          units_next = 4'd9;
          tens_next  = bcd_tens - 4'd1;
        end else begin
          units_next = bcd_units - 4'd1;
        end
      end else begin
        underflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      bcd_tens  <= 4'd0;
      bcd_units <= 4'd0;
    end else begin
      count     <= count_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
      bcd_tens  <= tens_next;
      bcd_units <= units_next;
    end
  end

  always_comb begin
    full  = (count == CAP);
    empty = (count == '0);
  end

  // Phase idles at 1 so the LED lights in the very cycle full rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!full) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_comb full_led = full & blink_phase;

endmodule
